// File: rtl/relu_maxpool2d_2x2_pkg.sv
// Shared FP32 constants and ReLU/max helpers for the 2x2 pooling stage.
package relu_maxpool2d_2x2_pkg;

  localparam int          FP32_WIDTH    = 32;
  localparam int          FP32_SIGN_BIT = FP32_WIDTH - 1;
  localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

  // ReLU on raw FP32 bits: any word with the sign set (including -0.0) becomes +0.0.
  function automatic logic [31:0] fp32_relu(input logic [31:0] raw);
    return raw[FP32_SIGN_BIT] ? FP32_ZERO : raw;
  endfunction

  // Max of two non-negative FP32 words. With the sign clear, IEEE-754 ordering equals
  // unsigned ordering of the raw bits, so +Inf and +NaN naturally win.
  function automatic logic [31:0] fp32_max(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // Combine an already rectified value with a fresh raw pixel.
  function automatic logic [31:0] fp32_relu_max(input logic [31:0] held, input logic [31:0] raw);
    return fp32_max(held, fp32_relu(raw));
  endfunction

endpackage

// File: rtl/relu_maxpool2d_2x2_line_buffer.sv
// Half-width line buffer holding the horizontal pair maxima of the even row.
// Write is synchronous, read is combinational; contents are not reset because every
// entry is written on the even row before the odd row reads it.
module relu_maxpool2d_2x2_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 56,
  parameter int AW         = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the even-row pair maximum for this column pair.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool2d_2x2.sv
// ReLU followed by 2x2 / stride-2 max pooling on a raster-order FP32 stream.
// Handshake: valid_in qualifies data_in for one cycle; there is no backpressure, the
// consumer takes every valid_out pulse. Only cycles with valid_in=1 advance the position.
module relu_maxpool2d_2x2
  import relu_maxpool2d_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DEPTH = (WIDTH / 2 > 0) ? WIDTH / 2 : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if ((WIDTH % 2) != 0 || (HEIGHT % 2) != 0) begin : g_bad_dims
      $error("relu_maxpool2d_2x2: WIDTH and HEIGHT must be even");
    end
    if (DATA_WIDTH != FP32_WIDTH) begin : g_bad_width
      $error("relu_maxpool2d_2x2: DATA_WIDTH must be 32 (FP32)");
    end
  endgenerate

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic [DATA_WIDTH-1:0] line_rdata;
  logic [AW-1:0]         buf_addr;
  logic                  col_last;
  logic                  row_last;
  logic                  line_we;

  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));
  assign buf_addr = AW'(col >> 1);

  // Horizontal pair max, then fold in the even-row pair stored in the line buffer.
  always_comb begin
    pair_max = fp32_relu_max(hold, data_in);
    win_max  = fp32_max(line_rdata, pair_max);
  end

  // Odd column of an even row writes; odd rows only read the same slot.
  assign line_we = valid_in & col[0] & ~row[0];

  relu_maxpool2d_2x2_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (line_we),
    .waddr (buf_addr),
    .wdata (pair_max),
    .raddr (buf_addr),
    .rdata (line_rdata)
  );

  // Position counters, left-pixel hold register and the registered pooled output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col[0]) begin
          hold <= fp32_relu(data_in);
        end else if (row[0]) begin
          data_out   <= win_max;
          valid_out  <= 1'b1;
          frame_done <= row_last & col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule
